addsub_result_stage: RTL
========================

Name: addsub_result_stage

Overview:
- Downstream capture stage for the 4-bit add/sub datapath. Registers each result (R, Cout) together with the operands and mode that produced it.
- Derives condition flags {V,N,Z,C} and buffers entries in a small FIFO with valid/ready handshake toward the consumer.
- Keeps a saturating count of signed-overflow events for status readout.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, minimum 2.
- CNT_W, 8, width of overflow event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result present this cycle.
- in_ready  output  1  stage can accept; equals !full.
- in_a  input  4  operand A presented to the add/sub stage.
- in_b  input  4  operand B, un-inverted.
- in_sub  input  1  mode; the Cin of the add/sub stage; 1 = subtract.
- in_r  input  4  R from the add/sub stage.
- in_cout  input  1  Cout from the add/sub stage; carry for add, borrow for subtract.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes the head entry.
- out_r  output  4  head result.
- out_flags  output  4  head flags {V,N,Z,C}.
- ovf_count  output  CNT_W  saturating count of accepted entries with V=1.
- cnt_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (async, rst_n=0): pointers and occupancy cleared; out_valid=0, in_ready=1, out_r=0, out_flags=0, ovf_count=0. Reset mid-transfer discards all entries.
- Push: in_valid && in_ready at the edge writes {in_r, flags} to the tail.
- Pop: out_valid && out_ready at the edge advances the head.
- Flags are computed combinationally at push and stored with the entry:
  - C = in_cout.
  - N = in_r[3].
  - Z = (in_r == 0).
  - V (add, in_sub=0) = (in_a[3]==in_b[3]) && (in_r[3]!=in_a[3]).
  - V (sub, in_sub=1) = (in_a[3]!=in_b[3]) && (in_r[3]!=in_a[3]).
- Latency: no bypass. An entry pushed at edge k is visible with out_valid=1 after edge k; minimum one cycle in-to-out.
- out_r and out_flags are 0 whenever out_valid=0.
- Full: in_ready=0; in_valid is ignored and no data is lost. A pop while full frees space from the next cycle only; in_ready is not combinationally dependent on out_ready.
- Empty: out_valid=0; out_ready is ignored.
- Simultaneous push and pop (not full, not empty): occupancy unchanged; head and tail both advance.
- Pointers wrap modulo DEPTH.
- ovf_count:
  - Increments by 1 on each push with V=1; saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets it to 0 on the next edge.
  - cnt_clr coinciding with an overflow push: clear wins, result 0.
- Holding in_valid without a handshake has no side effects.
- Upstream fields are sampled only on an accepted push.

Test Plan:
- Add overflow: a=7, b=1, sub=0, r=8, cout=0, out_ready=1 -> one cycle later out_valid=1, out_r=8, flags V=1 N=1 Z=0 C=0; ovf_count=1.
- Sub zero: a=3, b=3, sub=1, r=0, cout=0 -> flags V=0 N=0 Z=1 C=0; ovf_count unchanged.
- Sub borrow: a=2, b=5, sub=1, r=4'b1101, cout=1 -> flags V=0 N=1 Z=0 C=1.
- Sub overflow: a=4'b1000, b=1, sub=1, r=4'b0111, cout=0 -> V=1, N=0; then assert cnt_clr together with another V=1 push -> ovf_count=0.
- Backpressure: out_ready=0, push 3 entries back-to-back with DEPTH=2 -> in_ready drops after 2 accepts and entry 3 is held. Raise out_ready -> entries emerge in order 1,2,3 with no loss or duplication.
- Reset mid-stream: 2 entries buffered, pulse rst_n low asynchronously -> immediately out_valid=0, in_ready=1, ovf_count=0, out_r=0.

Source files
------------

// File: rtl/addsub_result_stage.sv
// Capture stage behind the 4-bit add/sub datapath: derives {V,N,Z,C} per result,
// buffers entries in a small valid/ready FIFO and counts signed-overflow pushes.
module addsub_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_sub,
    input  logic [3:0]       in_r,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_r,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             cnt_clr
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [3:0]    mem_r [DEPTH];
    logic [3:0]    mem_f [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          flag_v;
    logic [3:0]    in_flags;
    logic          unused_operand_bits;

    // Only the operand sign bits matter for overflow detection.
    assign unused_operand_bits = ^{in_a[2:0], in_b[2:0]};

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    // Subtract overflows when the operand signs differ, add when they match.
    always_comb begin
        flag_v = 1'b0;
        if (in_sub)
            flag_v = (in_a[3] != in_b[3]) && (in_r[3] != in_a[3]);
        else
            flag_v = (in_a[3] == in_b[3]) && (in_r[3] != in_a[3]);
    end

    assign in_flags = {flag_v, in_r[3], (in_r == 4'd0), in_cout};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr] <= in_r;
            mem_f[wr_ptr] <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Clear takes priority over a coincident overflow push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_count <= '0;
        else if (cnt_clr)
            ovf_count <= '0;
        else if (push && flag_v && (ovf_count != {CNT_W{1'b1}}))
            ovf_count <= ovf_count + CNT_W'(1);
    end

    assign out_r     = out_valid ? mem_r[rd_ptr] : 4'd0;
    assign out_flags = out_valid ? mem_f[rd_ptr] : 4'd0;

endmodule
